// File: rtl/src_ctrl_pkg.sv
// Shared definitions for the SRC control sequencers: opcodes, condition codes,
// sequencer state encoding and the datapath strobe bundle.
package src_ctrl_pkg;

  localparam logic [4:0] OP_BR    = 5'b10010;
  localparam logic [4:0] OP_JR    = 5'b10011;
  localparam logic [4:0] OP_JAL   = 5'b10100;
  localparam logic [3:0] LINK_REG = 4'd15;

  // Branch condition field IR[20:19]; evaluated by the CON flip-flop logic.
  typedef enum logic [1:0] {
    COND_ZR = 2'b00,
    COND_NZ = 2'b01,
    COND_PL = 2'b10,
    COND_MI = 2'b11
  } cond_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BR_T3 = 3'd1,
    ST_BR_T4 = 3'd2,
    ST_BR_T5 = 3'd3,
    ST_BR_T6 = 3'd4,
    ST_JR_T3 = 3'd5,
    ST_JL_T3 = 3'd6,
    ST_JL_T4 = 3'd7
  } state_t;

  typedef struct packed {
    logic [3:0] reg_sel;
    logic       r_out;
    logic       r_in;
    logic       con_in;
    logic       pc_out;
    logic       pc_in;
    logic       y_in;
    logic       c_out;
    logic       alu_add;
    logic       z_in;
    logic       zlow_out;
    logic       done;
  } strobe_t;

  function automatic logic is_seq_op(input logic [4:0] op);
    return (op == OP_BR) || (op == OP_JR) || (op == OP_JAL);
  endfunction

  // First execution step for a supported opcode; IDLE for anything else.
  function automatic state_t entry_state(input logic [4:0] op);
    state_t s;
    case (op)
      OP_BR:   s = ST_BR_T3;
      OP_JR:   s = ST_JR_T3;
      OP_JAL:  s = ST_JL_T3;
      default: s = ST_IDLE;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] bus_driver_count(input strobe_t s);
    return 2'(s.r_out) + 2'(s.pc_out) + 2'(s.c_out) + 2'(s.zlow_out);
  endfunction

endpackage

// File: rtl/branch_strobe_decode.sv
// Combinational decode of sequencer state into one-hot datapath strobes.
// Only pc_in in BR_T6 depends on a live input (con_q); everything else is Moore.
module branch_strobe_decode
  import src_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] ra_i,
  input  logic       con_q_i,
  output strobe_t    strobe_o
);

  always_comb begin
    strobe_o = '0;
    case (state_i)
      ST_BR_T3: begin
        strobe_o.reg_sel = ra_i;
        strobe_o.r_out   = 1'b1;
        strobe_o.con_in  = 1'b1;
      end
      ST_BR_T4: begin
        strobe_o.pc_out = 1'b1;
        strobe_o.y_in   = 1'b1;
      end
      ST_BR_T5: begin
        strobe_o.c_out   = 1'b1;
        strobe_o.alu_add = 1'b1;
        strobe_o.z_in    = 1'b1;
      end
      ST_BR_T6: begin
        strobe_o.zlow_out = 1'b1;
        strobe_o.pc_in    = con_q_i;
        strobe_o.done     = 1'b1;
      end
      ST_JR_T3: begin
        strobe_o.reg_sel = ra_i;
        strobe_o.r_out   = 1'b1;
        strobe_o.pc_in   = 1'b1;
        strobe_o.done    = 1'b1;
      end
      // Link write happens first so jal with Ra==LINK_REG jumps to the new link value.
      ST_JL_T3: begin
        strobe_o.pc_out  = 1'b1;
        strobe_o.reg_sel = LINK_REG;
        strobe_o.r_in    = 1'b1;
      end
      ST_JL_T4: begin
        strobe_o.reg_sel = ra_i;
        strobe_o.r_out   = 1'b1;
        strobe_o.pc_in   = 1'b1;
        strobe_o.done    = 1'b1;
      end
      default: strobe_o = '0;
    endcase
  end

endmodule

// File: rtl/branch_seq.sv
// Control sequencer for SRC br/jr/jal, steps T3 onward. Accepts start only in
// IDLE, holds Ra internally, and reports taken/illegal as registered flags.
module branch_seq
  import src_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        con_q,
  output logic [3:0]  reg_sel,
  output logic        r_out,
  output logic        r_in,
  output logic        con_in,
  output logic        pc_out,
  output logic        pc_in,
  output logic        y_in,
  output logic        c_out,
  output logic        alu_add,
  output logic        z_in,
  output logic        zlow_out,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        illegal
);

  state_t     state_q, state_d;
  logic [3:0] ra_q, ra_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;
  strobe_t    strobe;

  logic [4:0] ir_op;
  logic [3:0] ir_ra;
  logic       unused_ir_bits;

  assign ir_op          = ir[31:27];
  assign ir_ra          = ir[26:23];
  assign unused_ir_bits = ^ir[22:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ra_q      <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ra_q      <= ra_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    taken_d   = taken_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_seq_op(ir_op)) begin
            state_d = entry_state(ir_op);
            ra_d    = ir_ra;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_BR_T3: state_d = ST_BR_T4;
      ST_BR_T4: state_d = ST_BR_T5;
      ST_BR_T5: state_d = ST_BR_T6;
      ST_BR_T6: begin
        state_d = ST_IDLE;
        taken_d = con_q;
      end
      ST_JR_T3: begin
        state_d = ST_IDLE;
        taken_d = 1'b1;
      end
      ST_JL_T3: state_d = ST_JL_T4;
      ST_JL_T4: begin
        state_d = ST_IDLE;
        taken_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  branch_strobe_decode u_decode (
    .state_i  (state_q),
    .ra_i     (ra_q),
    .con_q_i  (con_q),
    .strobe_o (strobe)
  );

  always_comb begin
    reg_sel  = strobe.reg_sel;
    r_out    = strobe.r_out;
    r_in     = strobe.r_in;
    con_in   = strobe.con_in;
    pc_out   = strobe.pc_out;
    pc_in    = strobe.pc_in;
    y_in     = strobe.y_in;
    c_out    = strobe.c_out;
    alu_add  = strobe.alu_add;
    z_in     = strobe.z_in;
    zlow_out = strobe.zlow_out;
    done     = strobe.done;
    busy     = (state_q != ST_IDLE);
    taken    = taken_q;
    illegal  = illegal_q;
  end

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: per-cycle expected output words are queued as
// stimulus is driven and compared at each falling edge.
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] ir;
  logic        con_q;
  logic [3:0]  reg_sel;
  logic        r_out, r_in, con_in, pc_out, pc_in, y_in, c_out, alu_add;
  logic        z_in, zlow_out, busy, done, taken, illegal;

  branch_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ir       (ir),
    .con_q    (con_q),
    .reg_sel  (reg_sel),
    .r_out    (r_out),
    .r_in     (r_in),
    .con_in   (con_in),
    .pc_out   (pc_out),
    .pc_in    (pc_in),
    .y_in     (y_in),
    .c_out    (c_out),
    .alu_add  (alu_add),
    .z_in     (z_in),
    .zlow_out (zlow_out),
    .busy     (busy),
    .done     (done),
    .taken    (taken),
    .illegal  (illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Output word: {reg_sel, r_out, r_in, con_in, pc_out, pc_in, y_in, c_out,
  //               alu_add, z_in, zlow_out, busy, done, taken, illegal}
  localparam logic [17:0] M_ILL  = 18'h1 << 0;
  localparam logic [17:0] M_TAK  = 18'h1 << 1;
  localparam logic [17:0] M_DONE = 18'h1 << 2;
  localparam logic [17:0] M_BUSY = 18'h1 << 3;
  localparam logic [17:0] M_ZLOW = 18'h1 << 4;
  localparam logic [17:0] M_ZIN  = 18'h1 << 5;
  localparam logic [17:0] M_ADD  = 18'h1 << 6;
  localparam logic [17:0] M_COUT = 18'h1 << 7;
  localparam logic [17:0] M_YIN  = 18'h1 << 8;
  localparam logic [17:0] M_PCIN = 18'h1 << 9;
  localparam logic [17:0] M_PCO  = 18'h1 << 10;
  localparam logic [17:0] M_CON  = 18'h1 << 11;
  localparam logic [17:0] M_RIN  = 18'h1 << 12;
  localparam logic [17:0] M_ROUT = 18'h1 << 13;

  localparam logic [4:0] OPC_BR  = 5'b10010;
  localparam logic [4:0] OPC_JR  = 5'b10011;
  localparam logic [4:0] OPC_JAL = 5'b10100;
  localparam logic [4:0] OPC_ADD = 5'b00011;

  logic [17:0] obs_word;
  assign obs_word = {reg_sel, r_out, r_in, con_in, pc_out, pc_in, y_in, c_out,
                     alu_add, z_in, zlow_out, busy, done, taken, illegal};

  // scoreboard
  logic [17:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [17:0] rs(input logic [3:0] r);
    return {r, 14'd0};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [1:0] cond);
    return {op, ra, 2'b00, cond, 19'h1_2345};
  endfunction

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: advance one cycle and compare against the oldest queued expectation
  task automatic tick(input string tag);
    logic [17:0] e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s observed=%h expected=<queue empty>", tag, obs_word);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs_word, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    ir    = '0;
    con_q = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", obs_word, 18'h0);
    rst_n = 1'b1;
    exp_q.push_back(18'h0);
    tick("idle_after_reset");

    // 1: br zr Ra=3, con_q=1 -> taken
    ir = mk_ir(OPC_BR, 4'd3, 2'b00); start = 1'b1; con_q = 1'b1;
    exp_q.push_back(rs(4'd3) | M_ROUT | M_CON | M_BUSY);
    tick("br1_t3");
    start = 1'b0; ir = '0;
    exp_q.push_back(M_PCO | M_YIN | M_BUSY);
    tick("br1_t4");
    exp_q.push_back(M_COUT | M_ADD | M_ZIN | M_BUSY);
    tick("br1_t5");
    exp_q.push_back(M_ZLOW | M_PCIN | M_DONE | M_BUSY);
    tick("br1_t6");
    exp_q.push_back(M_TAK);
    tick("br1_idle_taken");

    // 2: br nz Ra=4, con_q high early but low in T6 -> not taken
    ir = mk_ir(OPC_BR, 4'd4, 2'b01); start = 1'b1; con_q = 1'b1;
    exp_q.push_back(rs(4'd4) | M_ROUT | M_CON | M_BUSY | M_TAK);
    tick("br2_t3");
    start = 1'b0;
    exp_q.push_back(M_PCO | M_YIN | M_BUSY | M_TAK);
    tick("br2_t4");
    con_q = 1'b0;
    exp_q.push_back(M_COUT | M_ADD | M_ZIN | M_BUSY | M_TAK);
    tick("br2_t5");
    exp_q.push_back(M_ZLOW | M_DONE | M_BUSY | M_TAK);
    tick("br2_t6");
    exp_q.push_back(18'h0);
    tick("br2_idle_not_taken");

    // 3: jal Ra=5
    ir = mk_ir(OPC_JAL, 4'd5, 2'b00); start = 1'b1;
    exp_q.push_back(rs(4'd15) | M_PCO | M_RIN | M_BUSY);
    tick("jal_t3");
    start = 1'b0; ir = mk_ir(OPC_JR, 4'd9, 2'b00);
    exp_q.push_back(rs(4'd5) | M_ROUT | M_PCIN | M_DONE | M_BUSY);
    tick("jal_t4");
    exp_q.push_back(M_TAK);
    tick("jal_idle_taken");

    // 4: unsupported opcode
    ir = mk_ir(OPC_ADD, 4'd2, 2'b00); start = 1'b1;
    exp_q.push_back(M_ILL | M_TAK);
    tick("illegal_pulse");
    start = 1'b0;
    exp_q.push_back(M_TAK);
    tick("illegal_cleared");

    // 5: start held through a br; ir changes mid-sequence; restart as jr after done
    ir = mk_ir(OPC_BR, 4'd2, 2'b10); start = 1'b1; con_q = 1'b1;
    exp_q.push_back(rs(4'd2) | M_ROUT | M_CON | M_BUSY | M_TAK);
    tick("hold_t3");
    ir = mk_ir(OPC_JR, 4'd7, 2'b00);
    exp_q.push_back(M_PCO | M_YIN | M_BUSY | M_TAK);
    tick("hold_t4");
    exp_q.push_back(M_COUT | M_ADD | M_ZIN | M_BUSY | M_TAK);
    tick("hold_t5");
    con_q = 1'b0;
    exp_q.push_back(M_ZLOW | M_DONE | M_BUSY | M_TAK);
    tick("hold_t6");
    exp_q.push_back(18'h0);
    tick("hold_done_ignored");
    exp_q.push_back(rs(4'd7) | M_ROUT | M_PCIN | M_DONE | M_BUSY);
    tick("restart_jr");
    start = 1'b0;
    exp_q.push_back(M_TAK);
    tick("jr_idle_taken");

    // 6: reset during BR_T5, then a clean br
    ir = mk_ir(OPC_BR, 4'd9, 2'b11); start = 1'b1; con_q = 1'b1;
    exp_q.push_back(rs(4'd9) | M_ROUT | M_CON | M_BUSY | M_TAK);
    tick("rst_t3");
    start = 1'b0;
    exp_q.push_back(M_PCO | M_YIN | M_BUSY | M_TAK);
    tick("rst_t4");
    exp_q.push_back(M_COUT | M_ADD | M_ZIN | M_BUSY | M_TAK);
    tick("rst_t5");
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", obs_word, 18'h0);
    @(negedge clk);
    check("reset_held", obs_word, 18'h0);
    rst_n = 1'b1;
    ir = mk_ir(OPC_BR, 4'd1, 2'b00); start = 1'b1; con_q = 1'b1;
    exp_q.push_back(rs(4'd1) | M_ROUT | M_CON | M_BUSY);
    tick("post_rst_t3");
    start = 1'b0;
    exp_q.push_back(M_PCO | M_YIN | M_BUSY);
    tick("post_rst_t4");
    exp_q.push_back(M_COUT | M_ADD | M_ZIN | M_BUSY);
    tick("post_rst_t5");
    exp_q.push_back(M_ZLOW | M_PCIN | M_DONE | M_BUSY);
    tick("post_rst_t6");
    exp_q.push_back(M_TAK);
    tick("post_rst_idle");

    // jal with Ra == LINK_REG: both steps select R15
    ir = mk_ir(OPC_JAL, 4'd15, 2'b00); start = 1'b1;
    exp_q.push_back(rs(4'd15) | M_PCO | M_RIN | M_BUSY | M_TAK);
    tick("jal15_t3");
    start = 1'b0;
    exp_q.push_back(rs(4'd15) | M_ROUT | M_PCIN | M_DONE | M_BUSY | M_TAK);
    tick("jal15_t4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
